// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns (abcdefg, active low)
// and width helpers used to size the scan index and slot counter.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b1110010;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // A single-digit build still needs a 1-bit index/counter rather than a zero-width vector.
   function automatic int width_of(input int n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low abcdefg segment pattern.
// Zero latency, no flow control.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_BLANK;
      unique case (nibble_i)
         4'h0: seg_n_o = SEG_0;
         4'h1: seg_n_o = SEG_1;
         4'h2: seg_n_o = SEG_2;
         4'h3: seg_n_o = SEG_3;
         4'h4: seg_n_o = SEG_4;
         4'h5: seg_n_o = SEG_5;
         4'h6: seg_n_o = SEG_6;
         4'h7: seg_n_o = SEG_7;
         4'h8: seg_n_o = SEG_8;
         4'h9: seg_n_o = SEG_9;
         4'hA: seg_n_o = SEG_A;
         4'hB: seg_n_o = SEG_B;
         4'hC: seg_n_o = SEG_C;
         4'hD: seg_n_o = SEG_D;
         4'hE: seg_n_o = SEG_E;
         4'hF: seg_n_o = SEG_F;
         default: seg_n_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver with shadow registers, LZ suppression and dead time.
// Outputs registered; a load becomes visible on the following edge; no backpressure (free-running scan).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int SLOT_CYCLES = 100000,
   parameter int DEAD_CYCLES = 2,
   parameter int LZ_BLANK    = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [4*NUM_DIGITS-1:0]         value,
   input  logic                            load,
   input  logic [NUM_DIGITS-1:0]           dp,
   input  logic [NUM_DIGITS-1:0]           blank,
   output logic [NUM_DIGITS-1:0]           an_n,
   output logic [6:0]                      seg_n,
   output logic                            dp_n,
   output logic [width_of(NUM_DIGITS)-1:0] scan_idx
);

   localparam int IDX_W = width_of(NUM_DIGITS);
   localparam int CNT_W = width_of(SLOT_CYCLES);

   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d, an_sel;
   logic [6:0]              seg_n_q, seg_n_d, dec_seg;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic                    zero_run;
   logic [3:0]              nib;
   logic                    dig_dark, dig_dp;

   // Outputs are built from the next-state shadow and scan position so both a load and a slot
   // wrap show up on the very edge that registers them.
   always_comb begin
      val_d   = load ? value : val_q;
      dp_d    = load ? dp    : dp_q;
      blank_d = load ? blank : blank_q;
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (int'(cnt_q) == SLOT_CYCLES - 1) begin
         cnt_d = '0;
         idx_d = (int'(idx_q) == NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      end
   end

   // Leading-zero mask: scan from the most significant digit, stop at the first non-zero nibble.
   always_comb begin
      zero_run = 1'b1;
      lz_dark  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (val_d[4*i +: 4] == 4'h0);
         if (i > 0) lz_dark[i] = zero_run & (LZ_BLANK != 0);
      end
   end

   always_comb begin
      nib      = 4'h0;
      dig_dark = 1'b1;
      dig_dp   = 1'b0;
      an_sel   = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (int'(idx_d) == i) begin
            nib       = val_d[4*i +: 4];
            dig_dark  = blank_d[i] | lz_dark[i];
            dig_dp    = dp_d[i] & ~blank_d[i];
            an_sel[i] = 1'b0;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble_i (nib),
      .seg_n_o  (dec_seg)
   );

   always_comb begin
      seg_n_d = dig_dark ? SEG_BLANK : dec_seg;
      dp_n_d  = ~dig_dp;
      an_n_d  = (int'(cnt_d) < DEAD_CYCLES) ? '1 : an_sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_q   <= '0;
         dp_q    <= '0;
         blank_q <= '1;
         cnt_q   <= '0;
         idx_q   <= '0;
         an_n_q  <= '1;
         seg_n_q <= SEG_BLANK;
         dp_n_q  <= 1'b1;
      end else begin
         val_q   <= val_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         an_n_q  <= an_n_d;
         seg_n_q <= seg_n_d;
         dp_n_q  <= dp_n_d;
      end
   end

   assign an_n     = an_n_q;
   assign seg_n    = seg_n_q;
   assign dp_n     = dp_n_q;
   assign scan_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits, 6-cycle slots, 2 dead cycles, LZ suppression on.
module tb_seg7_scan_driver;

   localparam int ND   = 4;
   localparam int SLOT = 6;
   localparam int DEAD = 2;

   logic          clk;
   logic          rst_n;
   logic [15:0]   value;
   logic          load;
   logic [3:0]    dp;
   logic [3:0]    blank;
   logic [3:0]    an_n;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [1:0]    scan_idx;

   seg7_scan_driver #(
      .NUM_DIGITS  (ND),
      .SLOT_CYCLES (SLOT),
      .DEAD_CYCLES (DEAD),
      .LZ_BLANK    (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .value    (value),
      .load     (load),
      .dp       (dp),
      .blank    (blank),
      .an_n     (an_n),
      .seg_n    (seg_n),
      .dp_n     (dp_n),
      .scan_idx (scan_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [3:0][6:0] seg;   // index = digit
      logic [3:0]      dpn;
   } vec_t;

   typedef struct packed {
      logic [1:0] dig;
      logic [6:0] seg;
      logic       dpn;
   } exp_t;

   int   n_vec  = 0;
   int   n_err  = 0;
   int   m_cnt  = 0;
   int   m_idx  = 0;
   int   cyc    = 0;
   int   prev_wrap = -1;
   int   last_wrap = -1;
   logic [1:0] prev_idx = 2'd0;
   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Bench-side slot/scan position, advanced from the reset and wrap rules.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_cnt = 0;
         m_idx = 0;
      end else if (m_cnt == SLOT - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % ND;
      end else begin
         m_cnt++;
      end
      #1;
      if (prev_idx == 2'd3 && scan_idx == 2'd0) begin
         prev_wrap = last_wrap;
         last_wrap = cyc;
      end
      prev_idx = scan_idx;
   endtask

   function automatic logic [3:0] exp_an();
      logic [3:0] one;
      one = 4'b0001;
      return (m_cnt < DEAD) ? 4'hF : ~(one << m_idx);
   endfunction

   task automatic wait_pos(input int idx, input int cnt);
      int n;
      n = 0;
      while (!(m_idx == idx && m_cnt == cnt) && n < 60) begin
         tick();
         n++;
      end
      if (!(m_idx == idx && m_cnt == cnt)) begin
         n_err++;
         $display("FAIL wait_pos timeout idx=%0d cnt=%0d", idx, cnt);
      end
   endtask

   // Continuous no-overlap check on the anode enables.
   always @(negedge clk) begin
      if ($countones(~an_n) > 1) begin
         n_err++;
         $display("FAIL overlap: an_n=%b has more than one low bit", an_n);
      end
   end

   vec_t tbl[8];
   exp_t cur;
   int   lows[4];

   initial begin
      tbl[0] = '{value:16'h12AF, dp:4'b0100, blank:4'b0000,
                 seg:{7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, dpn:4'b1011};
      tbl[1] = '{value:16'h0030, dp:4'b0000, blank:4'b0000,
                 seg:{7'h7F, 7'h7F, 7'b0000110, 7'b0000001}, dpn:4'b1111};
      tbl[2] = '{value:16'h0000, dp:4'b0000, blank:4'b0000,
                 seg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}, dpn:4'b1111};
      tbl[3] = '{value:16'h8888, dp:4'b1111, blank:4'b1010,
                 seg:{7'h7F, 7'b0000000, 7'h7F, 7'b0000000}, dpn:4'b1010};
      tbl[4] = '{value:16'h0B0C, dp:4'b0010, blank:4'b0000,
                 seg:{7'h7F, 7'b1100000, 7'b0000001, 7'b1110010}, dpn:4'b1101};
      tbl[5] = '{value:16'h0000, dp:4'b1000, blank:4'b0000,
                 seg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}, dpn:4'b0111};
      tbl[6] = '{value:16'hDE93, dp:4'b0000, blank:4'b0000,
                 seg:{7'b1000010, 7'b0110000, 7'b0000100, 7'b0000110}, dpn:4'b1111};
      tbl[7] = '{value:16'h4567, dp:4'b0000, blank:4'b0000,
                 seg:{7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111}, dpn:4'b1111};

      rst_n = 1'b0;
      value = 16'h0000;
      load  = 1'b0;
      dp    = 4'h0;
      blank = 4'h0;

      // Reset state
      repeat (3) tick();
      check("rst_an", an_n, 4'hF);
      check("rst_seg", seg_n, 7'h7F);
      check("rst_dpn", dp_n, 1'b1);
      check("rst_idx", scan_idx, 2'd0);

      // Dark until first load, regardless of live inputs
      rst_n = 1'b1;
      value = 16'hFFFF;
      dp    = 4'hF;
      for (int c = 0; c < 30; c++) begin
         tick();
         check("dark_seg_dp", {seg_n, dp_n}, 8'hFF);
         check("dark_scan", {scan_idx, an_n}, {2'(m_idx), exp_an()});
      end

      // Table-driven frames through the scoreboard
      for (int v = 0; v < 8; v++) begin
         value = tbl[v].value;
         dp    = tbl[v].dp;
         blank = tbl[v].blank;
         load  = 1'b1;
         for (int d = 0; d < ND; d++)
            sbq.push_back('{dig:2'(d), seg:tbl[v].seg[d], dpn:tbl[v].dpn[d]});
         tick();
         load  = 1'b0;
         value = 16'($urandom);
         dp    = 4'($urandom);
         blank = 4'($urandom);
         wait_pos(0, 0);
         for (int d = 0; d < ND; d++) lows[d] = 0;
         for (int c = 0; c < ND * SLOT; c++) begin
            check("scan", {scan_idx, an_n}, {2'(m_idx), exp_an()});
            if (m_cnt == 0) begin
               if (sbq.size() == 0) begin
                  n_err++;
                  $display("FAIL scoreboard empty at cyc %0d", cyc);
               end else begin
                  cur = sbq.pop_front();
                  check("digit", scan_idx, cur.dig);
                  check("seg", seg_n, cur.seg);
                  check("dpn", dp_n, cur.dpn);
               end
            end else if (m_cnt == SLOT - 1) begin
               check("seg_hold", {seg_n, dp_n}, {cur.seg, cur.dpn});
            end
            for (int d = 0; d < ND; d++) if (!an_n[d]) lows[d]++;
            tick();
         end
         for (int d = 0; d < ND; d++) check("on_cycles", lows[d], SLOT - DEAD);
      end
      check("scoreboard_drained", sbq.size(), 0);

      if (prev_wrap < 0) begin
         n_err++;
         $display("FAIL frame_period: fewer than two wraps seen");
      end else begin
         check("frame_period", last_wrap - prev_wrap, ND * SLOT);
      end

      // Mid-slot load: digit 0 showing "7" switches to "5" on the next edge, scan undisturbed
      wait_pos(0, 4);
      check("mid_pre_seg", seg_n, 7'b0001111);
      value = 16'h0005;
      dp    = 4'h0;
      blank = 4'h0;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      check("mid_seg", seg_n, 7'b0100100);
      check("mid_scan", {scan_idx, an_n}, {2'd0, 4'b1110});
      tick();
      check("mid_wrap", {scan_idx, an_n}, {2'd1, 4'b1111});
      check("mid_wrap_seg", seg_n, 7'h7F);

      // Reset mid-scan with a fully lit display
      value = 16'h8888;
      dp    = 4'hF;
      blank = 4'h0;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      wait_pos(2, 3);
      check("pre_rst_seg", {seg_n, dp_n, an_n}, {7'b0000000, 1'b0, 4'b1011});
      rst_n = 1'b0;
      tick();
      check("mrst_an", an_n, 4'hF);
      check("mrst_seg", seg_n, 7'h7F);
      check("mrst_dpn", dp_n, 1'b1);
      check("mrst_idx", scan_idx, 2'd0);
      rst_n = 1'b1;
      wait_pos(0, 3);
      check("post_rst_an", an_n, 4'b1110);
      check("post_rst_dark", {seg_n, dp_n}, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
